avalon_st_packet_checker: RTL
=============================

# avalon_st_packet_checker

Downstream sink for the concentrator's Avalon-ST output stream. It drives `sink_ready`, with optional pseudo-random backpressure, and consumes packets. For each packet it validates SOP/EOP framing, length and CRC-8, then reports per-packet status and saturating statistics. It sits in the check top-level directly after the concentrator and replaces the free `sink_ready` input as the stream consumer.

## Interface
Parameters:
- `MIN_LEN`, 3: minimum legal packet length in beats (header + ≥1 payload + CRC).
- `MAX_LEN`, 64: maximum legal packet length in beats; must be ≤255.
- `LFSR_SEED`, 8'hA5: backpressure LFSR reset value; must be non-zero.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain).
- `rst`  in  1  synchronous, active-high reset.
- `avalon_st_data`  in  8  stream byte.
- `avalon_st_valid`  in  1  source has a beat.
- `avalon_st_startofpacket`  in  1  first beat of packet.
- `avalon_st_endofpacket`  in  1  last beat of packet.
- `sink_ready`  out  1  sink accepts a beat this cycle (readyLatency 0).
- `stall_en`  in  1  1 = apply LFSR backpressure; 0 = always ready.
- `pkt_done`  out  1  one-cycle pulse: a packet verdict is published.
- `pkt_ok`  out  1  verdict of the last packet (1 = good).
- `last_channel`  out  8  header byte of the last packet that ended with EOP.
- `last_len`  out  8  beat count of that packet, saturating at 255.
- `pkt_count`  out  16  good packets, saturating at 16'hFFFF.
- `err_crc_count`  out  16  CRC failures, saturating.
- `err_frame_count`  out  16  framing or length failures, saturating.

## Operation
- Packet format: byte 0 = channel header, then payload, last byte = CRC-8 over all preceding bytes. CRC is poly 0x07, init 0x00, no reflection, no xorout.
- Check rule: the running CRC over all bytes including the CRC byte equals 0x00.
- A beat transfers when `avalon_st_valid & sink_ready`. Non-transfer cycles change no state other than the LFSR.
- FSM states:
  - IDLE: awaiting SOP.
  - BODY: inside a packet.
  - DROP: discarding beats until EOP.
- IDLE:
  - SOP beat without EOP: init CRC with the byte, len=1, capture header, go to BODY.
  - SOP and EOP on the same beat: frame error, stay in IDLE.
  - Beat without SOP: frame error, go to DROP. If that beat also has EOP, stay in IDLE instead.
- BODY:
  - Beat without SOP: update CRC, len+1.
  - If len would exceed MAX_LEN: frame error, go to DROP. If that beat has EOP, go to IDLE instead.
  - EOP with len<MIN_LEN: frame error.
  - Otherwise EOP: CRC result 0 gives a good packet, else a CRC error. Go to IDLE.
- SOP inside BODY: frame error for the aborted packet, then treat the beat as a fresh SOP (stay in BODY, restart len/CRC).
- DROP: discard beats. EOP returns to IDLE. SOP in DROP is handled as in IDLE.
- Exactly one verdict per error event. `err_*` and `pkt_count` saturate and never wrap.
- Backpressure: 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1, advancing every cycle. `sink_ready` is registered: it equals `!stall_en | lfsr[0]`, updated each cycle.

## Timing
- Reset values:
  - `sink_ready`=0 during reset, 1 on the first cycle after reset.
  - FSM=IDLE, LFSR=`LFSR_SEED`.
  - `pkt_done`=0, `pkt_ok`=0, `last_channel`=0, `last_len`=0.
  - All counters = 0.
- Verdict latency: 1 cycle. `pkt_done`, `pkt_ok`, counters and `last_*` update on the cycle after the deciding beat.
- `last_channel` and `last_len` update only on verdicts triggered by an EOP beat.
- Back-to-back packets: an EOP beat followed by a SOP beat on the next cycle is accepted at full rate with no bubble.
- `rst` asserted mid-packet discards the partial packet with no verdict. Counters clear.
- `stall_en` changes take effect on `sink_ready` one cycle later.

## Structure
- Package `concentrator_pkg` holds:
  - state enum IDLE/BODY/DROP
  - `CRC8_POLY`=8'h07
  - the default LFSR taps
- Sub-module `crc8_byte`: combinational next-CRC from (crc_in[7:0], data[7:0]). It is reused by the transmitter model.

## Test plan
- `stall_en`=0; send "123456789" (0x31..0x39) + 0xF4 with SOP on first, EOP on last → `pkt_done` pulse, `pkt_ok`=1, `last_channel`=0x31, `last_len`=10, `pkt_count`=1.
- Same packet with CRC byte 0xF5 → `pkt_ok`=0, `err_crc_count`=1, `pkt_count` unchanged.
- Stray beat without SOP, then valid packet → `err_frame_count`=1, the next packet is good.
- SOP, 2 bytes, then new SOP + full good packet → `err_frame_count`=1, `pkt_count`=1.
- 70-beat packet → one frame error, DROP until EOP; packets of length 2 and SOP+EOP single beat → one frame error each.
- `stall_en`=1, 100 back-to-back good packets → `sink_ready` follows LFSR sequence from 0xA5, all accepted, `pkt_count`=100; `rst` mid-packet → counters 0, no `pkt_done`.

Source files
------------

// File: rtl/concentrator_pkg.sv
// Shared definitions for the Avalon-ST packet checker.
//   state_e    : checker FSM states (awaiting SOP, inside a packet, dropping to EOP)
//   CRC8_POLY  : CRC-8 generator polynomial (x^8+x^2+x+1), MSB-first, init 0
//   LFSR_TAPS  : Fibonacci tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   lfsr_next  : one step of the backpressure LFSR, shifting left
package concentrator_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBody,
        StDrop
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/crc8_byte.sv
// Combinational CRC-8 update for one byte, MSB first, no reflection.
// Ports:
//   crc_in  [7:0] in   running CRC before this byte
//   data    [7:0] in   byte to fold in
//   crc_out [7:0] out  running CRC after this byte
module crc8_byte
    import concentrator_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[7]) begin
                crc_out = {crc_out[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                crc_out = {crc_out[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/avalon_st_packet_checker.sv
// Avalon-ST sink that drives sink_ready (optionally throttled by an LFSR),
// checks SOP/EOP framing, packet length and a trailing CRC-8, and publishes
// a per-packet verdict plus saturating statistics one cycle after the
// deciding beat.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   avalon_st_data [7:0]     stream byte
//   avalon_st_valid          source has a beat
//   avalon_st_startofpacket  first beat of packet
//   avalon_st_endofpacket    last beat of packet
//   sink_ready               registered ready (readyLatency 0)
//   stall_en                 1 = LFSR backpressure, 0 = always ready
//   pkt_done                 one-cycle verdict pulse
//   pkt_ok                   verdict of the last packet (1 = good)
//   last_channel [7:0]       header of the last packet decided on an EOP beat
//   last_len [7:0]           beat count of that packet, saturating at 255
//   pkt_count [15:0]         good packets, saturating
//   err_crc_count [15:0]     CRC failures, saturating
//   err_frame_count [15:0]   framing/length failures, saturating
module avalon_st_packet_checker
    import concentrator_pkg::*;
#(
    parameter int unsigned MIN_LEN   = 3,
    parameter int unsigned MAX_LEN   = 64,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  avalon_st_data,
    input  logic        avalon_st_valid,
    input  logic        avalon_st_startofpacket,
    input  logic        avalon_st_endofpacket,
    output logic        sink_ready,
    input  logic        stall_en,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic [7:0]  last_channel,
    output logic [7:0]  last_len,
    output logic [15:0] pkt_count,
    output logic [15:0] err_crc_count,
    output logic [15:0] err_frame_count
);

    localparam logic [8:0] MinLen9 = 9'(MIN_LEN);
    localparam logic [8:0] MaxLen9 = 9'(MAX_LEN);

    state_e      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  crc_q, crc_d;
    logic [7:0]  hdr_q, hdr_d;
    logic [7:0]  lfsr_q;
    logic        sink_ready_q;

    logic        pkt_done_q, pkt_ok_q;
    logic [7:0]  last_channel_q, last_len_q;
    logic [15:0] pkt_count_q, err_crc_count_q, err_frame_count_q;

    logic        xfer;
    logic        sop, eop;
    logic [7:0]  crc_in_sel, crc_nxt;
    logic [8:0]  len_inc;

    // Verdict produced by the current beat; registered into the outputs.
    logic        v_fire, v_ok, v_crc, v_frame, v_last;
    logic [7:0]  v_chan, v_len;

    assign xfer = avalon_st_valid & sink_ready_q;
    assign sop  = avalon_st_startofpacket;
    assign eop  = avalon_st_endofpacket;

    // A SOP beat seeds the CRC from zero; otherwise continue the running CRC.
    assign crc_in_sel = sop ? 8'h00 : crc_q;
    assign len_inc    = {1'b0, len_q} + 9'd1;

    crc8_byte u_crc8_byte (
        .crc_in  (crc_in_sel),
        .data    (avalon_st_data),
        .crc_out (crc_nxt)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        crc_d   = crc_q;
        hdr_d   = hdr_q;
        v_fire  = 1'b0;
        v_ok    = 1'b0;
        v_crc   = 1'b0;
        v_frame = 1'b0;
        v_last  = 1'b0;
        v_chan  = hdr_q;
        v_len   = len_inc[8] ? 8'hFF : len_inc[7:0];

        if (xfer) begin
            if (sop) begin
                // SOP aborts any open packet; the beat then starts a new one.
                if (state_q == StBody) begin
                    v_fire  = 1'b1;
                    v_frame = 1'b1;
                end
                if (eop) begin
                    // Single-beat packet: too short, decided on its EOP beat.
                    v_fire  = 1'b1;
                    v_frame = 1'b1;
                    v_last  = 1'b1;
                    v_chan  = avalon_st_data;
                    v_len   = 8'd1;
                    state_d = StIdle;
                end else begin
                    state_d = StBody;
                    len_d   = 8'd1;
                    crc_d   = crc_nxt;
                    hdr_d   = avalon_st_data;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        v_fire  = 1'b1;
                        v_frame = 1'b1;
                        state_d = eop ? StIdle : StDrop;
                    end
                    StDrop: begin
                        if (eop) begin
                            state_d = StIdle;
                        end
                    end
                    StBody: begin
                        if (len_inc > MaxLen9) begin
                            v_fire  = 1'b1;
                            v_frame = 1'b1;
                            v_last  = eop;
                            state_d = eop ? StIdle : StDrop;
                        end else if (eop) begin
                            v_fire  = 1'b1;
                            v_last  = 1'b1;
                            state_d = StIdle;
                            if (len_inc < MinLen9) begin
                                v_frame = 1'b1;
                            end else if (crc_nxt == 8'h00) begin
                                v_ok = 1'b1;
                            end else begin
                                v_crc = 1'b1;
                            end
                        end else begin
                            len_d = len_inc[7:0];
                            crc_d = crc_nxt;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            len_q        <= 8'd0;
            crc_q        <= 8'd0;
            hdr_q        <= 8'd0;
            lfsr_q       <= LFSR_SEED;
            sink_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            crc_q        <= crc_d;
            hdr_q        <= hdr_d;
            lfsr_q       <= lfsr_next(lfsr_q);
            sink_ready_q <= ~stall_en | lfsr_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_done_q        <= 1'b0;
            pkt_ok_q          <= 1'b0;
            last_channel_q    <= 8'd0;
            last_len_q        <= 8'd0;
            pkt_count_q       <= 16'd0;
            err_crc_count_q   <= 16'd0;
            err_frame_count_q <= 16'd0;
        end else begin
            pkt_done_q <= v_fire;
            if (v_fire) begin
                pkt_ok_q <= v_ok;
            end
            if (v_last) begin
                last_channel_q <= v_chan;
                last_len_q     <= v_len;
            end
            if (v_ok && pkt_count_q != 16'hFFFF) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
            if (v_crc && err_crc_count_q != 16'hFFFF) begin
                err_crc_count_q <= err_crc_count_q + 16'd1;
            end
            if (v_frame && err_frame_count_q != 16'hFFFF) begin
                err_frame_count_q <= err_frame_count_q + 16'd1;
            end
        end
    end

    assign sink_ready      = sink_ready_q;
    assign pkt_done        = pkt_done_q;
    assign pkt_ok          = pkt_ok_q;
    assign last_channel    = last_channel_q;
    assign last_len        = last_len_q;
    assign pkt_count       = pkt_count_q;
    assign err_crc_count   = err_crc_count_q;
    assign err_frame_count = err_frame_count_q;

endmodule
